// File: rtl/mpdiv_prog.sv
// ---------------------------------------------------------------------------
// mpdiv_prog
// Programmable multi-phase divider. A modulo-div_q counter drives NPH
// interleaved phase clocks spaced one CLK apart. Each phase latches a
// pseudo-random dither code for the downstream DTC on its rising edge.
//
// Ports
//   CLK     in   1       sole clock, rising edge
//   NARST   in   1       asynchronous active-low reset
//   DIV     in   CW      requested divide ratio, taken only at period wrap
//   DEN     in   1       dither enable
//   FMP     out  NPH     registered phase clocks
//   DCODE   out  NPH*DW  per-phase dither codes, phase k at [k*DW +: DW]
//   WRAP    out  1       registered pulse at the start of each period
//   DIV_ACT out  CW      divide ratio currently in effect
// ---------------------------------------------------------------------------
module mpdiv_prog #(
  parameter int          NPH     = 8,
  parameter int          CW      = 6,
  parameter int          DIV_DEF = 8,
  parameter int          DW      = 6,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                CLK,
  input  logic                NARST,
  input  logic [CW-1:0]       DIV,
  input  logic                DEN,
  output logic [NPH-1:0]      FMP,
  output logic [NPH*DW-1:0]   DCODE,
  output logic                WRAP,
  output logic [CW-1:0]       DIV_ACT
);

  // Phase arithmetic is done at a width that holds both the phase index
  // (up to 15) and cnt+div_q without overflow.
  localparam int KW = ((CW > 5) ? CW : 5) + 1;

  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     r_div_q;
  logic [NPH-1:0]    r_fmp;
  logic [NPH*DW-1:0] r_dcode;
  logic              r_wrap;
  logic [15:0]       r_lfsr;

  logic              w_last;
  logic [CW-1:0]     w_cnt_nxt;
  logic [CW-1:0]     w_div_nxt;
  logic [15:0]       w_lfsr_nxt;
  logic [KW-1:0]     w_cnt_e;
  logic [KW-1:0]     w_div_e;
  logic [KW-1:0]     w_half;
  logic [NPH-1:0]    w_fmp_nxt;
  logic [NPH-1:0]    w_rise;
  logic [NPH*DW-1:0] w_code;

  assign w_last  = (r_cnt == (r_div_q - CW'(1)));
  assign w_cnt_e = KW'(r_cnt);
  assign w_div_e = KW'(r_div_q);
  assign w_half  = w_div_e >> 1;

  // Counter, shadow ratio load and LFSR next-state.
  always_comb begin
    w_cnt_nxt  = r_cnt + CW'(1);
    w_div_nxt  = r_div_q;
    w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    if (w_last) begin
      w_cnt_nxt = '0;
      // Ratios below 2 are ignored; the previous ratio stays in effect.
      if (DIV >= CW'(2)) begin
        w_div_nxt = DIV;
      end else begin
        w_div_nxt = r_div_q;
      end
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  for (genvar k = 0; k < NPH; k++) begin : g_ph
    logic [KW-1:0] w_d;
    // Distance of this phase behind phase 0, modulo div_q.
    assign w_d = (w_cnt_e >= KW'(k)) ? (w_cnt_e - KW'(k))
                                     : (w_cnt_e + w_div_e - KW'(k));
    // Phases beyond the active ratio are parked low.
    assign w_fmp_nxt[k] = (KW'(k) >= w_div_e) ? 1'b0 : (w_d < w_half);
    assign w_rise[k]    = w_fmp_nxt[k] & ~r_fmp[k];
    assign w_code[k*DW +: DW] = DEN ? (r_lfsr[DW-1:0] ^ DW'(k)) : {DW{1'b0}};
  end

  // State and registered outputs; dither codes update only on their phase's rise.
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      r_cnt   <= '0;
      r_div_q <= CW'(DIV_DEF);
      r_fmp   <= '0;
      r_dcode <= '0;
      r_wrap  <= 1'b0;
      r_lfsr  <= SEED;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_div_q <= w_div_nxt;
      r_fmp   <= w_fmp_nxt;
      r_wrap  <= (r_cnt == CW'(0));
      r_lfsr  <= w_lfsr_nxt;
      for (int k = 0; k < NPH; k++) begin
        if (w_rise[k]) begin
          r_dcode[k*DW +: DW] <= w_code[k*DW +: DW];
        end else begin
          r_dcode[k*DW +: DW] <= r_dcode[k*DW +: DW];
        end
      end
    end
  end

  assign FMP     = r_fmp;
  assign DCODE   = r_dcode;
  assign WRAP    = r_wrap;
  assign DIV_ACT = r_div_q;

endmodule

// File: tb/tb_mpdiv_prog.sv
module tb_mpdiv_prog;

  localparam int          NPH     = 8;
  localparam int          CW      = 6;
  localparam int          DIV_DEF = 8;
  localparam int          DW      = 6;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic                CLK = 1'b0;
  logic                NARST = 1'b0;
  logic [CW-1:0]       DIV = CW'(8);
  logic                DEN = 1'b1;
  logic [NPH-1:0]      FMP;
  logic [NPH*DW-1:0]   DCODE;
  logic                WRAP;
  logic [CW-1:0]       DIV_ACT;

  mpdiv_prog #(.NPH(NPH), .CW(CW), .DIV_DEF(DIV_DEF), .DW(DW), .SEED(SEED)) dut (
    .CLK(CLK), .NARST(NARST), .DIV(DIV), .DEN(DEN),
    .FMP(FMP), .DCODE(DCODE), .WRAP(WRAP), .DIV_ACT(DIV_ACT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NPH-1:0]    fmp;
    logic [NPH*DW-1:0] dcode;
    logic              wrap;
    logic [CW-1:0]     div;
  } exp_t;

  exp_t q[$];
  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state (behavioural, from the divider's rules)
  int                mcnt;
  int                mdiv;
  logic [15:0]       ml;
  logic [NPH-1:0]    mfmp;
  logic [NPH*DW-1:0] mdcode;

  task automatic model_reset();
    mcnt = 0; mdiv = DIV_DEF; ml = SEED; mfmp = '0; mdcode = '0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic step(input int div, input logic den);
    exp_t e;
    logic [NPH-1:0] nf;
    @(negedge CLK);
    DIV = CW'(div);
    DEN = den;
    for (int k = 0; k < NPH; k++) begin
      if (k < mdiv) nf[k] = (((mcnt - k + mdiv) % mdiv) < (mdiv / 2));
      else          nf[k] = 1'b0;
    end
    for (int k = 0; k < NPH; k++) begin
      if (nf[k] && !mfmp[k])
        mdcode[k*DW +: DW] = den ? (ml[DW-1:0] ^ DW'(k)) : {DW{1'b0}};
    end
    e.wrap = (mcnt == 0);
    if (mcnt == mdiv - 1) begin
      mcnt = 0;
      if (div >= 2) mdiv = div;
    end else begin
      mcnt = mcnt + 1;
    end
    ml = {ml[14:0], ^(ml & 16'hB400)};
    mfmp = nf;
    e.fmp = nf;
    e.dcode = mdcode;
    e.div = CW'(mdiv);
    q.push_back(e);
  endtask

  // Monitor: every output sample is compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if (FMP !== e.fmp || DCODE !== e.dcode || WRAP !== e.wrap || DIV_ACT !== e.div) begin
          n_fail++;
          $display("FAIL vec@%0t: FMP=%h/%h DCODE=%h/%h WRAP=%b/%b DIV_ACT=%0d/%0d (got/expected)",
                   $time, FMP, e.fmp, DCODE, e.dcode, WRAP, e.wrap, DIV_ACT, e.div);
        end
      end
    end
  end

  initial begin
    int rdiv;
    logic rden;
    int guard;
    model_reset();
    #12;
    chk("reset_fmp", 64'(FMP), 64'h0);
    chk("reset_dcode", 64'(DCODE), 64'h0);
    chk("reset_wrap", 64'(WRAP), 64'h0);
    chk("reset_divact", 64'(DIV_ACT), 64'd8);

    // Release and default ratio
    @(posedge CLK); #3; NARST = 1'b1;
    step(8, 1'b1);
    @(posedge CLK); #2;
    chk("first_fmp", 64'(FMP), 64'hE1);
    chk("first_dcode0", 64'(DCODE[DW-1:0]), 64'h21);
    for (int i = 0; i < 20; i++) step(8, 1'b1);

    // Ratio change requested mid-period at cnt=3
    while (mcnt != 3) step(8, 1'b1);
    for (int i = 0; i < 40; i++) step(12, 1'b1);

    // Odd ratio below the phase count
    for (int i = 0; i < 30; i++) step(5, 1'b1);

    // Illegal ratios
    for (int i = 0; i < 24; i++) step(i % 2, 1'b1);

    // Dither disable, then grow back above NPH
    for (int i = 0; i < 20; i++) step(5, 1'b0);
    for (int i = 0; i < 30; i++) step(10, 1'b1);

    // Randomised ratios and dither enable
    rdiv = 8; rden = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) rdiv = $urandom_range(0, 17);
      if ($urandom_range(0, 23) == 0) rden = ~rden;
      step(rdiv, rden);
    end

    // Reset mid-operation at cnt=5 with ratio 12
    guard = 0;
    step(12, 1'b1);
    while (!(mdiv == 12 && mcnt == 5) && guard < 200) begin
      step(12, 1'b1);
      guard++;
    end
    chk("reach_cnt5", 64'(guard < 200), 64'd1);
    @(posedge CLK); #2;
    NARST = 1'b0;
    #1;
    chk("midrst_fmp", 64'(FMP), 64'h0);
    chk("midrst_dcode", 64'(DCODE), 64'h0);
    chk("midrst_wrap", 64'(WRAP), 64'h0);
    chk("midrst_divact", 64'(DIV_ACT), 64'd8);
    model_reset();
    repeat (2) @(posedge CLK);
    #3; NARST = 1'b1;
    step(12, 1'b1);
    @(posedge CLK); #2;
    chk("rerun_fmp", 64'(FMP), 64'hE1);
    chk("rerun_dcode0", 64'(DCODE[DW-1:0]), 64'h21);
    chk("rerun_divact", 64'(DIV_ACT), 64'd8);
    for (int i = 0; i < 40; i++) step(12, 1'b1);

    @(posedge CLK); #3;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mpdiv_prog.md
# mpdiv_prog

Programmable multi-phase divider that generates NPH interleaved phase clocks. The phases are spaced one CLK period apart, and the divide ratio can be changed at runtime. Each phase also carries a per-edge pseudo-random dither code that drives a downstream digital-to-time converter; this code replaces behavioural delay modelling. The block sits between the high-speed CLK source and the phase-select/DTC stage of the fractional output divider.

## Interface

- NPH, default 8: number of output phases (2..16).
- CW, default 6: divide-ratio/counter width.
- DIV_DEF, default 8: divide ratio loaded at reset (must satisfy 2 ≤ DIV_DEF < 2^CW).
- DW, default 6: dither code width per phase (1..16).
- SEED, default 16'hACE1: LFSR reset value (nonzero).

Ports (clock and reset first):

- CLK, input, 1: sole clock; all state updates on rising edge.
- NARST, input, 1: asynchronous, active-low reset.
- DIV, input, CW: requested divide ratio; sampled only at period wrap.
- DEN, input, 1: dither enable.
- FMP, output, NPH: registered phase clocks.
- DCODE, output, NPH*DW: per-phase dither codes; phase k occupies bits [k*DW +: DW].
- WRAP, output, 1: registered one-cycle pulse marking the start of each divided period.
- DIV_ACT, output, CW: divide ratio currently in effect.

## Operation

- Counter cnt (CW bits) counts modulo div_q: next = (cnt == div_q−1) ? 0 : cnt+1.
- div_q is the active ratio, with reset value DIV_DEF.
- Shadow load of the ratio:
  - On the edge where cnt == div_q−1, div_q ← DIV if DIV ≥ 2; otherwise div_q is kept unchanged.
  - A DIV change at any other time has no effect until the next wrap.
- Phase generation for phase k, computed from the pre-update cnt and div_q:
  - If k ≥ div_q, then FMP[k] ← 0.
  - Otherwise d = (cnt ≥ k) ? cnt−k : cnt+div_q−k, and FMP[k] ← (d < div_q>>1).
  - Even ratios give 50% duty. Odd ratios are high for floor(div_q/2) cycles.
- WRAP ← (cnt == 0), using the pre-update cnt.
- DIV_ACT = div_q.
- LFSR:
  - 16-bit Fibonacci, shifts left every CLK: l ← {l[14:0], l[15]^l[13]^l[12]^l[10]}.
  - Reset value is SEED. It runs regardless of DEN.
- Dither capture, per phase k:
  - On the edge where FMP[k] is being set 0→1 (next value 1, current value 0), DCODE_k ← DEN ? l[DW−1:0] ^ k[DW−1:0] : 0.
  - Otherwise DCODE_k holds.
  - The pre-shift l is used.
- DEN deassertion does not clear DCODE immediately; each field goes to 0 at that phase's next rising edge.

## Timing

- Reset values: cnt=0, div_q=DIV_DEF, FMP=0, DCODE=0, WRAP=0, l=SEED.
- FMP and WRAP have one cycle of latency from cnt.
  - For DIV_DEF=8, the first edge after NARST release gives FMP=8'b1110_0001 and WRAP=1.
- Steady state, phase k: rises one CLK after phase k−1 and has period div_q CLK.
- DCODE_k changes on the same edge that FMP[k] rises; it is stable for the whole high and low of that period.
- A ratio change becomes visible in DIV_ACT one cycle after the wrap edge. The first period at the new ratio starts with WRAP on the following edge.
- Phases with k ≥ new div_q drop to 0 on the first edge evaluated with the new div_q. They restart cleanly when the ratio grows, with no partial pulse shorter than one CLK.
- Reset mid-operation: all outputs return to reset values asynchronously. The sequence restarts exactly as after power-up. The DIV value at reset release is ignored until the first wrap.

## Test plan

- Reset/default:
  - Stimulus: release NARST with DIV=8.
  - Required: FMP cycles 0xE1, 0xC3, 0x87, 0x0F, 0x1E, 0x3C, 0x78, 0xF0; WRAP high every 8th cycle; DIV_ACT=8.
- Ratio change mid-period:
  - Stimulus: set DIV=12 while cnt=3.
  - Required: DIV_ACT stays 8 until the wrap. Then phase 0 has period 12, high 6 cycles, and phases 0..7 are still spaced 1 CLK apart.
- Odd ratio below phase count:
  - Stimulus: DIV=5, NPH=8.
  - Required: FMP[4:0] each high 2 of 5 cycles, staggered by 1; FMP[7:5] constantly 0; WRAP period 5.
- Illegal ratio:
  - Stimulus: DIV=1 and DIV=0 presented across wraps.
  - Required: DIV_ACT and waveforms are unchanged from the prior ratio.
- Dither capture:
  - Stimulus: DEN=1 with SEED=16'hACE1.
  - Required: DCODE_0 on the first FMP[0] rise equals 6'h21. Each DCODE_k equals a golden-model LFSR sample XOR k at its rise edge. After DEN=0, each field reads 0 after its next rise.
- Reset mid-operation:
  - Stimulus: assert NARST at cnt=5 with DIV_ACT=12 (DIV_DEF=8).
  - Required: outputs clear immediately. After release, the sequence matches the reset/default scenario and the LFSR restarts from SEED.
